// File: rtl/ram512_mover.sv
// ram512_mover - block-transfer engine for a 512 x 16 synchronous RAM port
// (registered read data, write-first-cycle-read-old).
// Executes one command at a time: FILL a region with a constant, COPY a region,
// SUM a region, or (optional) CMP two regions. Regions wrap 0x1FF -> 0x000.
//
// Optional feature macro: RAM512_MOVER_CMP_EN (op 11 = CMP; undefined -> op 11 is illegal)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, op             command strobe (sampled in IDLE only), opcode
//   src_addr, dst_addr    9-bit region bases
//   len                   word count, legal 1..512
//   fill_data             FILL constant
//   busy, done, error     status; error is valid with the one-cycle done pulse
//   result                SUM total or CMP mismatch count
//   mem_addr/we/wdata     RAM address, write enable, write data
//   mem_rdata             RAM read data (address of the previous cycle)
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for start
// FILL     | one write per cycle of fill_data
// CP_RD    | COPY: read source word
// CP_WR    | COPY: write the word just read to the destination
// SUM_RD   | SUM: pipelined reads, accumulate previous read
// SUM_LAST | SUM: absorb the final word
// CMP_S    | CMP: read source, compare previous pair
// CMP_D    | CMP: read destination, capture source word
// CMP_LAST | CMP: compare the final pair
// FIN      | done pulse, back to IDLE
module ram512_mover (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [8:0]  src_addr,
  input  logic [8:0]  dst_addr,
  input  logic [9:0]  len,
  input  logic [15:0] fill_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] result,
  output logic [8:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [3:0] {
    IDLE, FILL, CP_RD, CP_WR, SUM_RD, SUM_LAST, FIN
`ifdef RAM512_MOVER_CMP_EN
    , CMP_S, CMP_D, CMP_LAST
`endif
  } state_t;

  state_t      state;
  logic [9:0]  cnt;      // words remaining after the current one
  logic [8:0]  ptr_s;
  logic [8:0]  ptr_d;
  logic        first;    // no read data in flight yet
  logic [15:0] wdata_q;
  logic        op_bad;

`ifdef RAM512_MOVER_CMP_EN
  logic [15:0] cap;
  assign op_bad = 1'b0;
`else
  assign op_bad = (op == 2'b11);
`endif

  // COPY writes the word the RAM is presenting this cycle, so that path is combinational.
  assign mem_wdata = (state == CP_WR) ? mem_rdata : wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result   <= 16'h0000;
      mem_addr <= 9'h000;
      mem_we   <= 1'b0;
      wdata_q  <= 16'h0000;
      cnt      <= 10'd0;
      ptr_s    <= 9'h000;
      ptr_d    <= 9'h000;
      first    <= 1'b0;
`ifdef RAM512_MOVER_CMP_EN
      cap      <= 16'h0000;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error  <= 1'b0;
            result <= 16'h0000;
            if (len == 10'd0 || len > 10'd512 || op_bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              busy  <= 1'b1;
              cnt   <= len - 10'd1;
              first <= 1'b1;
              ptr_s <= src_addr + 9'd1;
              ptr_d <= dst_addr + 9'd1;
              case (op)
                2'b00: begin
                  mem_addr <= dst_addr;
                  mem_we   <= 1'b1;
                  wdata_q  <= fill_data;
                  state    <= FILL;
                end
                2'b01: begin
                  mem_addr <= src_addr;
                  ptr_d    <= dst_addr;
                  state    <= CP_RD;
                end
                2'b10: begin
                  mem_addr <= src_addr;
                  state    <= SUM_RD;
                end
`ifdef RAM512_MOVER_CMP_EN
                2'b11: begin
                  mem_addr <= src_addr;
                  ptr_d    <= dst_addr;
                  state    <= CMP_S;
                end
`endif
                default: state <= IDLE;
              endcase
            end
          end
        end
        FILL: begin
          if (cnt == 10'd0) begin
            mem_we  <= 1'b0;
            wdata_q <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FIN;
          end else begin
            mem_addr <= ptr_d;
            ptr_d    <= ptr_d + 9'd1;
            cnt      <= cnt - 10'd1;
          end
        end
        CP_RD: begin
          mem_addr <= ptr_d;
          ptr_d    <= ptr_d + 9'd1;
          mem_we   <= 1'b1;
          state    <= CP_WR;
        end
        CP_WR: begin
          mem_we <= 1'b0;
          if (cnt == 10'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            mem_addr <= ptr_s;
            ptr_s    <= ptr_s + 9'd1;
            cnt      <= cnt - 10'd1;
            state    <= CP_RD;
          end
        end
        SUM_RD: begin
          first <= 1'b0;
          if (!first) result <= result + mem_rdata;
          if (cnt == 10'd0) begin
            state <= SUM_LAST;
          end else begin
            mem_addr <= ptr_s;
            ptr_s    <= ptr_s + 9'd1;
            cnt      <= cnt - 10'd1;
          end
        end
        SUM_LAST: begin
          result <= result + mem_rdata;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= FIN;
        end
`ifdef RAM512_MOVER_CMP_EN
        CMP_S: begin
          first <= 1'b0;
          if (!first && mem_rdata != cap && result != 16'hFFFF) result <= result + 16'd1;
          mem_addr <= ptr_d;
          ptr_d    <= ptr_d + 9'd1;
          state    <= CMP_D;
        end
        CMP_D: begin
          cap <= mem_rdata;
          if (cnt == 10'd0) begin
            state <= CMP_LAST;
          end else begin
            mem_addr <= ptr_s;
            ptr_s    <= ptr_s + 9'd1;
            cnt      <= cnt - 10'd1;
            state    <= CMP_S;
          end
        end
        CMP_LAST: begin
          if (mem_rdata != cap && result != 16'hFFFF) result <= result + 16'd1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_mover.sv
// Testbench for ram512_mover: behavioural 512 x 16 RAM, directed commands,
// expected done responses queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_ram512_mover;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [8:0]  src = 9'h000;
  logic [8:0]  dst = 9'h000;
  logic [9:0]  len = 10'd0;
  logic [15:0] fill = 16'h0000;
  logic        busy, done, error, mem_we;
  logic [15:0] result, mem_wdata;
  logic [15:0] mem_rdata;
  logic [8:0]  mem_addr;

  always #5 clk = ~clk;

  ram512_mover dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_addr(src), .dst_addr(dst), .len(len), .fill_data(fill),
    .busy(busy), .done(done), .error(error), .result(result),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM model with a bench-side preload port
  logic [15:0] ram [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = 9'h000;
  logic [15:0] pl_data = 16'h0000;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    logic        err;
    logic [15:0] res;
    int          wr;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // monitor: counts writes since the last accept and checks each done pulse
  int wr_cnt = 0;
  int last_acc = -1;
  always @(negedge clk) begin
    exp_t e;
    if (acc != last_acc) begin
      last_acc = acc;
      wr_cnt = 0;
    end
    if (mem_we) wr_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: actual done=1 required done=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc - acc + 1, e.lat);
        chk("error", {31'd0, error}, {31'd0, e.err});
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("write_count", wr_cnt, e.wr);
        chk("busy_with_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: actual no done required done within 3000 cycles");
      sb.delete();
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [8:0] s, input logic [8:0] d,
                       input logic [9:0] l, input logic [15:0] f, input int lat,
                       input logic e, input logic [15:0] r, input int wr, input bit poke);
    exp_t x;
    x.lat = lat; x.err = e; x.res = r; x.wr = wr;
    sb.push_back(x);
    @(negedge clk);
    op = o; src = s; dst = d; len = l; fill = f; start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    // later input changes must not affect the running command
    op = ~o; src = ~s; dst = ~d; len = 10'd1; fill = ~f;
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1; op = 2'b00;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // FILL with wrap
    preload(9'h002, 16'h5555);
    issue(2'b00, 9'h000, 9'h1FE, 10'd4, 16'hABCD, 5, 1'b0, 16'h0000, 4, 1'b0);
    chk("fill_1fe", {16'd0, ram[9'h1FE]}, 32'hABCD);
    chk("fill_1ff", {16'd0, ram[9'h1FF]}, 32'hABCD);
    chk("fill_000", {16'd0, ram[9'h000]}, 32'hABCD);
    chk("fill_001", {16'd0, ram[9'h001]}, 32'hABCD);
    chk("fill_002_untouched", {16'd0, ram[9'h002]}, 32'h5555);

    // COPY
    preload(9'h010, 16'h0001);
    preload(9'h011, 16'h0002);
    preload(9'h012, 16'h0003);
    issue(2'b01, 9'h010, 9'h100, 10'd3, 16'h0000, 7, 1'b0, 16'h0000, 3, 1'b0);
    chk("copy_100", {16'd0, ram[9'h100]}, 32'h0001);
    chk("copy_101", {16'd0, ram[9'h101]}, 32'h0002);
    chk("copy_102", {16'd0, ram[9'h102]}, 32'h0003);

    // SUM with carry discarded, start during busy ignored
    preload(9'h020, 16'hFFFF);
    preload(9'h021, 16'h0002);
    preload(9'h022, 16'h0010);
    preload(9'h023, 16'h0000);
    issue(2'b10, 9'h020, 9'h000, 10'd4, 16'h0000, 6, 1'b0, 16'h0011, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("sum_hold", {16'd0, result}, 32'h0011);

    // illegal commands
    issue(2'b00, 9'h000, 9'h050, 10'd0, 16'h1111, 1, 1'b1, 16'h0000, 0, 1'b0);
    issue(2'b01, 9'h000, 9'h050, 10'd513, 16'h1111, 1, 1'b1, 16'h0000, 0, 1'b0);
`ifndef RAM512_MOVER_CMP_EN
    issue(2'b11, 9'h000, 9'h050, 10'd4, 16'h1111, 1, 1'b1, 16'h0000, 0, 1'b0);
`endif

    // reset in the middle of a COPY
    for (int i = 0; i < 8; i++) begin
      preload(9'h040 + 9'(i), 16'h0011 + 16'(i));
      preload(9'h140 + 9'(i), 16'h0000);
    end
    @(negedge clk);
    op = 2'b01; src = 9'h040; dst = 9'h140; len = 10'd8; start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_copy_140", {16'd0, ram[9'h140]}, 32'h0011);
    chk("rst_copy_141", {16'd0, ram[9'h141]}, 32'h0012);
    for (int i = 2; i < 8; i++)
      chk("rst_copy_untouched", {16'd0, ram[9'h140 + 9'(i)]}, 32'h0000);

    // FILL after reset release
    preload(9'h082, 16'h7777);
    issue(2'b00, 9'h000, 9'h080, 10'd2, 16'h1234, 3, 1'b0, 16'h0000, 2, 1'b0);
    chk("fill2_080", {16'd0, ram[9'h080]}, 32'h1234);
    chk("fill2_081", {16'd0, ram[9'h081]}, 32'h1234);
    chk("fill2_082_untouched", {16'd0, ram[9'h082]}, 32'h7777);

`ifdef RAM512_MOVER_CMP_EN
    // CMP: two mismatching pairs, start during busy ignored
    preload(9'h030, 16'h0001);
    preload(9'h031, 16'h0002);
    preload(9'h032, 16'h0003);
    preload(9'h033, 16'h0004);
    preload(9'h0A0, 16'h0001);
    preload(9'h0A1, 16'h0009);
    preload(9'h0A2, 16'h0003);
    preload(9'h0A3, 16'h0008);
    issue(2'b11, 9'h030, 9'h0A0, 10'd4, 16'h0000, 10, 1'b0, 16'h0002, 0, 1'b1);
    chk("cmp_dst_untouched", {16'd0, ram[9'h0A1]}, 32'h0009);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
